// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and a wait-stated memory (slave).
// The memory answers each request with a single-cycle mem_ack pulse.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: req/ack handshake with a wait-stated data memory, byte-lane steering,
// core stall generation, and sticky misalignment / bus-timeout flags.
module load_store_unit #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      MemWrite,
    input  logic                      MemRead,
    input  logic                      ByteAcc,
    input  logic [31:0]               Addr,
    input  logic [31:0]               WriteData,
    output logic [31:0]               ReadData,
    output logic                      Stall,
    input  logic                      err_clr,
    output logic                      bus_err,
    output logic                      align_err,
    load_store_unit_if.master         mem
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [7:0] CntMax = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        byte_q, byte_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_err_q, bus_err_d;
    logic        align_err_q, align_err_d;

    logic        req;
    logic        misaligned;
    logic        bus_set;
    logic        align_set;
    logic [7:0]  rd_byte;

    assign req        = MemWrite | MemRead;
    assign misaligned = !ByteAcc && (Addr[1:0] != 2'b00);
    assign rd_byte    = mem.mem_rdata[{lane_q, 3'b000} +: 8];

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        we_d      = we_q;
        byte_d    = byte_q;
        lane_d    = lane_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        bus_set   = 1'b0;
        align_set = 1'b0;

        case (state_q)
            StIdle: begin
                if (req) begin
                    // A simultaneous MemWrite/MemRead is treated as a store.
                    we_d    = MemWrite;
                    byte_d  = ByteAcc;
                    lane_d  = Addr[1:0];
                    addr_d  = {Addr[31:2], 2'b00};
                    be_d    = ByteAcc ? (4'b0001 << Addr[1:0]) : 4'b1111;
                    wdata_d = ByteAcc ? {4{WriteData[7:0]}} : WriteData;
                    if (misaligned) begin
                        state_d   = StDone;
                        align_set = 1'b1;
                        rdata_d   = '0;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                cnt_d = cnt_q + 8'd1;
                if (mem.mem_ack) begin
                    state_d = StDone;
                    if (!we_q) begin
                        rdata_d = byte_q ? {24'd0, rd_byte} : mem.mem_rdata;
                    end
                end else if (cnt_q == CntMax) begin
                    state_d = StDone;
                    bus_set = 1'b1;
                    if (!we_q) begin
                        rdata_d = ERR_DATA;
                    end
                end
            end
            StDone: begin
                // The core still presents the same instruction here; it is not a new request.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        bus_err_d   = bus_set | (bus_err_q & ~err_clr);
        align_err_d = align_set | (align_err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            lane_q      <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            byte_q      <= byte_d;
            lane_q      <= lane_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
            align_err_q <= align_err_d;
        end
    end

    assign Stall = reset && ((state_q == StReq) || ((state_q == StIdle) && req));

    assign mem.mem_req   = (state_q == StReq);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

    assign ReadData  = rdata_q;
    assign bus_err   = bus_err_q;
    assign align_err = align_err_q;

endmodule
